// File: rtl/frame_enc_pkg.sv
// Shared types, default K characters and the CRC-8 step used by the frame encoder.
package frame_enc_pkg;

    typedef enum logic [1:0] {StIdle, StPay, StCrc, StEof} state_e;

    localparam logic [7:0] K_SOF_DEF  = 8'hBC;  // K28.5
    localparam logic [7:0] K_EOF_DEF  = 8'hFD;  // K29.7
    localparam logic [7:0] K_IDLE_DEF = 8'h3C;  // K28.1

    // One byte through a non-reflected, MSB-first CRC-8, no final XOR.
    function automatic logic [7:0] crc8_update(input logic [7:0] data,
                                               input logic [7:0] crc,
                                               input logic [7:0] poly);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ data[i];
            c  = {c[6:0], 1'b0} ^ (fb ? poly : 8'h00);
        end
        return c;
    endfunction

endpackage

// File: rtl/encoder_8b10b.sv
// Registered 8b10b encoder with running disparity; output bit order {j,h,g,f,i,e,d,c,b,a}.
module encoder_8b10b (
    input  logic       clk,
    input  logic       reset,
    input  logic       KI,
    input  logic [7:0] datain,
    output logic [9:0] dataout
);

    logic [9:0] dataout_q, dataout_d;
    logic       rd_q, rd_d;
    logic [5:0] six;   // abcdei, a in bit 5
    logic [3:0] four;  // fghj, f in bit 3
    logic       unbal6, unbal4, rd_mid, a7;
    logic [4:0] x;
    logic [2:0] y;

    assign x = datain[4:0];
    assign y = datain[7:5];

    // 5b/6b then 3b/4b lookup, each sub-block complemented according to running disparity.
    always_comb begin
        six = 6'b000000;
        unique case (x)
            5'd0:  six = 6'b100111;  5'd1:  six = 6'b011101;
            5'd2:  six = 6'b101101;  5'd3:  six = 6'b110001;
            5'd4:  six = 6'b110101;  5'd5:  six = 6'b101001;
            5'd6:  six = 6'b011001;  5'd7:  six = 6'b111000;
            5'd8:  six = 6'b111001;  5'd9:  six = 6'b100101;
            5'd10: six = 6'b010101;  5'd11: six = 6'b110100;
            5'd12: six = 6'b001101;  5'd13: six = 6'b101100;
            5'd14: six = 6'b011100;  5'd15: six = 6'b010111;
            5'd16: six = 6'b011011;  5'd17: six = 6'b100011;
            5'd18: six = 6'b010011;  5'd19: six = 6'b110010;
            5'd20: six = 6'b001011;  5'd21: six = 6'b101010;
            5'd22: six = 6'b011010;  5'd23: six = 6'b111010;
            5'd24: six = 6'b110011;  5'd25: six = 6'b100110;
            5'd26: six = 6'b010110;  5'd27: six = 6'b110110;
            5'd28: six = 6'b001110;  5'd29: six = 6'b101110;
            5'd30: six = 6'b011110;  5'd31: six = 6'b101011;
        endcase
        if (KI && x == 5'd28) six = 6'b001111;
        unbal6 = ($countones(six) != 3);
        // D.7 is balanced but still alternates between two forms.
        if (rd_q && (unbal6 || x == 5'd7)) six = ~six;
        rd_mid = rd_q ^ unbal6;

        // Alternate x.7 form avoids a run of five identical bits across the sub-block boundary.
        a7 = KI || (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20))
                || (rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14));
        four = 4'b0000;
        unique case (y)
            3'd0: four = 4'b1011;
            3'd1: four = 4'b1001;
            3'd2: four = 4'b0101;
            3'd3: four = 4'b1100;
            3'd4: four = 4'b1101;
            3'd5: four = 4'b1010;
            3'd6: four = 4'b0110;
            3'd7: four = a7 ? 4'b0111 : 4'b1110;
        endcase
        unbal4 = ($countones(four) != 2);
        if (rd_mid && (unbal4 || y == 3'd3)) four = ~four;
        // K characters use the opposite balanced 4b form to keep the comma unique.
        if (KI && !rd_mid && (y == 3'd1 || y == 3'd2 || y == 3'd5 || y == 3'd6)) four = ~four;
        rd_d = rd_mid ^ unbal4;

        dataout_d = {four[0], four[1], four[2], four[3],
                     six[0], six[1], six[2], six[3], six[4], six[5]};
    end

    // Symbol register and running disparity (RD- after reset).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dataout_q <= 10'h000;
            rd_q      <= 1'b0;
        end else begin
            dataout_q <= dataout_d;
            rd_q      <= rd_d;
        end
    end

    assign dataout = dataout_q;

endmodule

// File: rtl/frame_crc_encoder.sv
// Frame builder (SOF, payload, optional CRC-8, EOF, idle fill) feeding a registered 8b10b encoder.
module frame_crc_encoder
    import frame_enc_pkg::*;
#(
    parameter int unsigned PAYLOAD_LEN = 8,
    parameter bit          CRC_EN      = 1'b1,
    parameter logic [7:0]  CRC_POLY    = 8'h07,
    parameter logic [7:0]  CRC_INIT    = 8'h00,
    parameter logic [7:0]  K_SOF       = K_SOF_DEF,
    parameter logic [7:0]  K_EOF       = K_EOF_DEF,
    parameter logic [7:0]  K_IDLE      = K_IDLE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_en,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [9:0] data_out,
    output logic [7:0] sym_byte,
    output logic       sym_k,
    output logic       frame_done,
    output logic       busy
);

    localparam int unsigned    CntW    = $clog2(PAYLOAD_LEN + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(PAYLOAD_LEN - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      crc_q, crc_d;
    logic [7:0]      st1_byte_q, st1_byte_d;
    logic            st1_k_q, st1_k_d;
    logic            st1_done_q, st1_done_d;
    logic            busy_q, busy_d;
    logic [7:0]      sym_byte_q;
    logic            sym_k_q, frame_done_q;

    assign s_ready = (state_q == StPay);

    // Next state and the symbol issued into stage 1 this cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        st1_byte_d = K_IDLE;
        st1_k_d    = 1'b1;
        st1_done_d = 1'b0;
        busy_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                // An EOF just issued forces one idle before the next SOF.
                if (tx_en && s_valid && !st1_done_q) begin
                    st1_byte_d = K_SOF;
                    crc_d      = CRC_INIT;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = StPay;
                end
            end
            StPay: begin
                busy_d = 1'b1;
                if (s_valid) begin
                    st1_byte_d = s_data;
                    st1_k_d    = 1'b0;
                    crc_d      = crc8_update(s_data, crc_q, CRC_POLY);
                    cnt_d      = cnt_q + CntW'(1);
                    if (cnt_q == CntLast) state_d = CRC_EN ? StCrc : StEof;
                end
            end
            StCrc: begin
                busy_d     = 1'b1;
                st1_byte_d = crc_q;
                st1_k_d    = 1'b0;
                state_d    = StEof;
            end
            StEof: begin
                busy_d     = 1'b1;
                st1_byte_d = K_EOF;
                st1_done_d = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state, stage-1 issue register and the stage-2 delay matching the encoder.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            crc_q        <= CRC_INIT;
            st1_byte_q   <= K_IDLE;
            st1_k_q      <= 1'b1;
            st1_done_q   <= 1'b0;
            busy_q       <= 1'b0;
            sym_byte_q   <= 8'h00;
            sym_k_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            crc_q        <= crc_d;
            st1_byte_q   <= st1_byte_d;
            st1_k_q      <= st1_k_d;
            st1_done_q   <= st1_done_d;
            busy_q       <= busy_d;
            sym_byte_q   <= st1_byte_q;
            sym_k_q      <= st1_k_q;
            frame_done_q <= st1_done_q;
        end
    end

    encoder_8b10b u_enc (
        .clk     (clk),
        .reset   (reset),
        .KI      (st1_k_q),
        .datain  (st1_byte_q),
        .dataout (data_out)
    );

    assign sym_byte   = sym_byte_q;
    assign sym_k      = sym_k_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_frame_crc_encoder.sv
// Directed bench: CRC frame, underrun fill, back-to-back frames, short no-CRC frame, reset abort.
module tb_frame_crc_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_en, s_valid, s_ready, sym_k, frame_done, busy;
    logic [7:0] s_data, sym_byte;
    logic [9:0] data_out;
    logic       tx_en1, s_valid1, s_ready1, sym_k1, frame_done1, busy1;
    logic [7:0] s_data1, sym_byte1;
    logic [9:0] data_out1;

    int   total = 0;
    int   bad   = 0;
    logic chk_en = 1'b0;
    logic cap_en = 1'b0;
    logic rd_m   = 1'b0;
    logic [9:0] cap_q[$];
    logic [9:0] cap1_q[$];
    logic [9:0] exp_q[$];

    localparam logic [9:0] EIdle = {2'b01, 8'h3C};

    always #5 clk = ~clk;

    frame_crc_encoder #(.PAYLOAD_LEN(9), .CRC_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset), .tx_en(tx_en), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .data_out(data_out), .sym_byte(sym_byte), .sym_k(sym_k),
        .frame_done(frame_done), .busy(busy)
    );

    frame_crc_encoder #(.PAYLOAD_LEN(1), .CRC_EN(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .tx_en(tx_en1), .s_data(s_data1), .s_valid(s_valid1),
        .s_ready(s_ready1), .data_out(data_out1), .sym_byte(sym_byte1), .sym_k(sym_k1),
        .frame_done(frame_done1), .busy(busy1)
    );

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Running-disparity check; K symbols are compared against hand-encoded values.
    task automatic check_symbol();
        int         ones;
        logic [9:0] e;
        ones = $countones(data_out);
        if (sym_k) begin
            case (sym_byte)
                8'h3C:   e = rd_m ? 10'h183 : 10'h27C;
                8'hBC:   e = rd_m ? 10'h283 : 10'h17C;
                8'hFD:   e = rd_m ? 10'h3A2 : 10'h05D;
                default: e = 10'h000;
            endcase
            chk({22'b0, data_out}, {22'b0, e}, "k_symbol");
        end else begin
            chk({31'b0, (ones == 5) || (ones == 6 && !rd_m) || (ones == 4 && rd_m)}, 1,
                "disparity");
        end
        if (ones == 6) rd_m = 1'b1;
        else if (ones == 4) rd_m = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            rd_m = 1'b0;
        end else begin
            if (cap_en) begin
                cap_q.push_back({frame_done, sym_k, sym_byte});
                cap1_q.push_back({frame_done1, sym_k1, sym_byte1});
            end
            if (chk_en) check_symbol();
        end
    end

    task automatic push(input int which, input logic [7:0] b);
        int n = 0;
        if (which == 0) begin
            s_data  = b;
            s_valid = 1'b1;
            while (!s_ready && n < 20) begin cyc(); n++; end
        end else begin
            s_data1  = b;
            s_valid1 = 1'b1;
            while (!s_ready1 && n < 20) begin cyc(); n++; end
        end
        chk({31'b0, n < 20}, 1, "push_wait");
        cyc();
    endtask

    task automatic check_stream(input int which, input string tag);
        logic [9:0] got[$];
        int         s = 0;
        if (which == 0) got = cap_q;
        else got = cap1_q;
        while (s < got.size() && got[s] == EIdle) s++;
        chk({31'b0, got.size() >= s + exp_q.size()}, 1, {tag, "_len"});
        for (int i = 0; i < exp_q.size(); i++)
            if (s + i < got.size())
                chk({22'b0, got[s+i]}, {22'b0, exp_q[i]}, $sformatf("%s[%0d]", tag, i));
    endtask

    // Expected stage-2 entries {done, k, byte} for the "123456789" frame; CRC-8 check value F4.
    task automatic exp_frame9(input bit with_gap);
        exp_q.push_back({2'b01, 8'hBC});
        for (int i = 1; i <= 9; i++) begin
            exp_q.push_back({2'b00, 8'(8'h30 + i)});
            if (with_gap && i == 4) repeat (3) exp_q.push_back(EIdle);
        end
        exp_q.push_back({2'b00, 8'hF4});
        exp_q.push_back({2'b11, 8'hFD});
    endtask

    initial begin
        reset = 1'b1;
        tx_en = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        tx_en1 = 1'b0; s_valid1 = 1'b0; s_data1 = 8'h00;
        repeat (2) cyc();
        chk({22'b0, data_out}, 0, "rst_data_out");
        chk({24'b0, sym_byte}, 0, "rst_sym_byte");
        chk({29'b0, sym_k, frame_done, busy}, 0, "rst_flags");
        chk({31'b0, s_ready}, 0, "rst_s_ready");
        chk({22'b0, data_out1}, 0, "rst_data_out1");
        reset = 1'b0;
        cyc();
        chk({22'b0, data_out}, 10'h27C, "first_idle_rdneg");
        chk_en = 1'b1;
        cyc();
        chk({22'b0, data_out}, 10'h183, "second_idle_rdpos");

        // Valid data without tx_en is never consumed.
        s_valid = 1'b1; s_data = 8'h55;
        repeat (20) begin
            cyc();
            chk({21'b0, sym_k, s_ready, busy, sym_byte}, {21'b0, 3'b100, 8'h3C}, "idle_hold");
        end
        s_valid = 1'b0;
        cap_en = 1'b1;

        // CRC frame with latency probe.
        cap_q.delete(); exp_q.delete();
        tx_en = 1'b1; s_data = 8'h31; s_valid = 1'b1;
        cyc();
        chk({31'b0, s_ready}, 1, "ready_in_pay");
        chk({31'b0, busy}, 1, "busy_at_sof");
        cyc();
        chk({23'b0, sym_k, sym_byte}, {23'b0, 1'b1, 8'hBC}, "sof_out");
        s_data = 8'h32;
        cyc();
        chk({23'b0, sym_k, sym_byte}, {23'b0, 1'b0, 8'h31}, "latency_first_byte");
        for (int i = 3; i <= 9; i++) push(0, 8'(8'h30 + i));
        tx_en = 1'b0; s_valid = 1'b0;
        repeat (6) cyc();
        exp_frame9(1'b0); exp_q.push_back(EIdle);
        check_stream(0, "crc_frame");
        chk({31'b0, busy}, 0, "busy_after_frame");

        // Underrun after byte 4.
        cap_q.delete(); exp_q.delete();
        tx_en = 1'b1;
        for (int i = 1; i <= 4; i++) push(0, 8'(8'h30 + i));
        s_valid = 1'b0;
        repeat (3) cyc();
        for (int i = 5; i <= 9; i++) push(0, 8'(8'h30 + i));
        tx_en = 1'b0; s_valid = 1'b0;
        repeat (6) cyc();
        exp_frame9(1'b1); exp_q.push_back(EIdle);
        check_stream(0, "underrun_frame");

        // Two queued frames: exactly one idle between them.
        cap_q.delete(); exp_q.delete();
        tx_en = 1'b1;
        repeat (2) for (int i = 1; i <= 9; i++) push(0, 8'(8'h30 + i));
        tx_en = 1'b0; s_valid = 1'b0;
        repeat (6) cyc();
        exp_frame9(1'b0); exp_q.push_back(EIdle);
        exp_frame9(1'b0); exp_q.push_back(EIdle);
        check_stream(0, "back_to_back");

        // One-byte frame without CRC.
        cap1_q.delete(); exp_q.delete();
        tx_en1 = 1'b1;
        push(1, 8'hA5);
        tx_en1 = 1'b0; s_valid1 = 1'b0;
        repeat (6) cyc();
        exp_q.push_back({2'b01, 8'hBC}); exp_q.push_back({2'b00, 8'hA5});
        exp_q.push_back({2'b11, 8'hFD}); exp_q.push_back(EIdle);
        check_stream(1, "short_nocrc");

        // Reset mid-frame after the 4th payload byte.
        tx_en = 1'b1;
        for (int i = 1; i <= 4; i++) push(0, 8'(8'h30 + i));
        chk_en = 1'b0; cap_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk({22'b0, data_out}, 0, "abort_data_out");
        chk({24'b0, sym_byte}, 0, "abort_sym_byte");
        chk({28'b0, sym_k, frame_done, busy, s_ready}, 0, "abort_flags");
        tx_en = 1'b0; s_valid = 1'b0;
        repeat (2) cyc();
        reset = 1'b0; s_valid = 1'b1; s_data = 8'h77;
        cyc();
        chk({22'b0, data_out}, 10'h27C, "post_reset_idle");
        chk_en = 1'b1;
        repeat (5) begin
            cyc();
            chk({22'b0, sym_k, busy, sym_byte}, {22'b0, 2'b10, 8'h3C}, "post_reset_fill");
        end
        cap_q.delete(); exp_q.delete(); cap_en = 1'b1;
        tx_en = 1'b1;
        for (int i = 1; i <= 9; i++) push(0, 8'(8'h30 + i));
        tx_en = 1'b0; s_valid = 1'b0;
        repeat (6) cyc();
        exp_frame9(1'b0); exp_q.push_back(EIdle);
        check_stream(0, "post_reset_frame");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
